// File: rtl/segway_auth_pkg.sv
// Shared constants and state types for the segway command authorizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package segway_auth_pkg;

  // Command bytes recognised by the authorization FSM
  localparam logic [7:0] CMD_START = 8'h47;  // 'G'
  localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'

  // Sample index of the stop bit (0 = start, 1..8 = data, 9 = stop)
  localparam logic [3:0] RX_STOP_IDX = 4'd9;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    PWR1 = 2'd1,
    PWR2 = 2'd2
  } auth_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/segway_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and start-bit glitch rejection.
// Latency: rx_rdy/rx_data one clock after the mid-stop-bit sample.
// Backpressure: none; output pulses must be consumed on the cycle they appear.
// Optional: SEGWAY_AUTH_FRAME_CHK_EN drops frames with a bad stop bit and pulses frame_err.
module segway_uart_rx
  import segway_auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err
);

  localparam int unsigned   CW      = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_DIV - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          start_edge;

  // Synchronize the async line; preset high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Falling edge, held off during the rx_rdy cycle so a new frame starts after it
  assign start_edge = rx_prev_q & ~rx_sync_q & ~rx_rdy_q;

`ifdef SEGWAY_AUTH_FRAME_CHK_EN
  logic frame_err_q, frame_err_d;
`endif

  // Receiver sequencing: half-bit delay to centre, then one sample per bit period
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = 1'b0;
`ifdef SEGWAY_AUTH_FRAME_CHK_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = RECV;
          baud_cnt_d = HALF_LD;
          bit_cnt_d  = 4'd0;
        end
      end
      RECV: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end else begin
          baud_cnt_d = BAUD_LD;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            // Start bit read high: a glitch, not a frame
            if (rx_sync_q) begin
              state_d    = IDLE;
              baud_cnt_d = '0;
              bit_cnt_d  = 4'd0;
            end
          end else if (bit_cnt_q == RX_STOP_IDX) begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            bit_cnt_d  = 4'd0;
`ifdef SEGWAY_AUTH_FRAME_CHK_EN
            if (rx_sync_q) begin
              rx_rdy_d  = 1'b1;
              rx_data_d = shift_q;
            end else begin
              frame_err_d = 1'b1;
            end
`else
            rx_rdy_d  = 1'b1;
            rx_data_d = shift_q;
`endif
          end else begin
            // LSB first: shift in from the top
            shift_d = {rx_sync_q, shift_q[7:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_rdy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

`ifdef SEGWAY_AUTH_FRAME_CHK_EN
  // Frame error pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;

endmodule

// File: rtl/segway_cmd_auth.sv
// Segway power authorization: UART command bytes 'G'/'S' plus rider_off drive pwr_up.
// Latency: pwr_up follows the FSM state one clock after each transition edge.
// Backpressure: none; commands are acted on in their rx_rdy cycle only.
// Optional: SEGWAY_AUTH_FRAME_CHK_EN enables stop-bit checking in the receiver.
module segway_cmd_auth
  import segway_auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err
);

  auth_state_e state_q, state_d;
  logic        pwr_up_q;

  segway_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err)
  );

  // Authorization next state; rider_off wins over a simultaneous 'S'
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (rx_rdy && (rx_data == CMD_START)) state_d = PWR1;
      end
      PWR1: begin
        if (rx_rdy && (rx_data == CMD_STOP)) state_d = rider_off ? OFF : PWR2;
      end
      PWR2: begin
        if (rider_off)                             state_d = OFF;
        else if (rx_rdy && (rx_data == CMD_START)) state_d = PWR1;
      end
      default: state_d = OFF;
    endcase
  end

  // State register and registered enable (one clock behind the state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      pwr_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwr_up_q <= (state_q != OFF);
    end
  end

  assign pwr_up = pwr_up_q;

endmodule

// File: tb/tb_segway_cmd_auth.sv
module tb_segway_cmd_auth;
  import segway_auth_pkg::*;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int   ferr_cnt = 0;
  int   wide_cnt = 0;
  logic rdy_prev = 1'b0;

  segway_cmd_auth #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rider_off (rider_off),
    .pwr_up    (pwr_up),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: record received bytes, frame errors and over-long rx_rdy pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_rdy) begin
        obs_q.push_back(rx_data);
        if (rdy_prev) wide_cnt++;
      end
      if (frame_err) ferr_cnt++;
    end
    rdy_prev = rx_rdy;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_val;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic get_obs(output logic [7:0] got, output bit timed_out);
    int cnt;
    cnt = 0;
    while (obs_q.size() == 0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (obs_q.size() == 0) begin
      timed_out = 1'b1;
      got = 8'hxx;
    end else begin
      timed_out = 1'b0;
      got = obs_q.pop_front();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (pwr_up !== 1'b0 || rx_rdy !== 1'b0 || frame_err !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: pwr_up=%b rx_rdy=%b frame_err=%b rx_data=%h, expected 0 0 0 00",
               pwr_up, rx_rdy, frame_err, rx_data);
    end
  endtask

  task automatic test_start_cmd();
    logic [7:0] got, e;
    bit to;
    rider_off = 1'b0;
    exp_q.push_back(CMD_START);
    send_byte(CMD_START, 1'b1);
    get_obs(got, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL start_rx_data: got %h (timeout=%0d) expected %h", got, to, e);
    end
    idle(3);
    n_checks++;
    if (pwr_up !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pwr_up: got %b expected 1", pwr_up);
    end
  endtask

  task automatic test_stop_to_pwr2();
    logic [7:0] got, e;
    bit to;
    exp_q.push_back(CMD_STOP);
    send_byte(CMD_STOP, 1'b1);
    get_obs(got, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL pwr2_rx_data: got %h (timeout=%0d) expected %h", got, to, e);
    end
    idle(3);
    n_checks++;
    if (pwr_up !== 1'b1) begin
      n_fail++;
      $display("FAIL pwr2_pwr_up: got %b expected 1", pwr_up);
    end
    @(negedge clk);
    rider_off = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pwr_up !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr2_rider_off: pwr_up got %b expected 0 within 2 clocks", pwr_up);
    end
    @(negedge clk);
    rider_off = 1'b0;
    idle(4);
  endtask

  task automatic test_regrant();
    logic [7:0] got, e;
    bit to;
    logic [7:0] seq [3];
    seq[0] = CMD_START; seq[1] = CMD_STOP; seq[2] = CMD_START;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(seq[k]);
      send_byte(seq[k], 1'b1);
      get_obs(got, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || got !== e) begin
        n_fail++;
        $display("FAIL regrant_rx_data[%0d]: got %h (timeout=%0d) expected %h", k, got, to, e);
      end
      idle(3);
      n_checks++;
      if (pwr_up !== 1'b1) begin
        n_fail++;
        $display("FAIL regrant_pwr_up[%0d]: got %b expected 1", k, pwr_up);
      end
    end
    // Back in PWR1: rider_off alone must not drop power
    rider_off = 1'b1;
    idle(6);
    n_checks++;
    if (pwr_up !== 1'b1) begin
      n_fail++;
      $display("FAIL pwr1_rider_off_hold: pwr_up got %b expected 1", pwr_up);
    end
    // 'S' while rider_off is high in PWR1 goes straight to OFF
    exp_q.push_back(CMD_STOP);
    send_byte(CMD_STOP, 1'b1);
    get_obs(got, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL stop_rider_off_rx_data: got %h (timeout=%0d) expected %h", got, to, e);
    end
    idle(3);
    n_checks++;
    if (pwr_up !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_rider_off_pwr_up: got %b expected 0", pwr_up);
    end
    rider_off = 1'b0;
    idle(4);
  endtask

  task automatic test_glitch();
    logic [7:0] got, e;
    bit to;
    @(negedge clk);
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(40);
    n_checks++;
    if (obs_q.size() != 0 || pwr_up !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reject: frames got %0d expected 0, pwr_up got %b expected 0",
               obs_q.size(), pwr_up);
    end
    exp_q.push_back(CMD_START);
    send_byte(CMD_START, 1'b1);
    get_obs(got, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL glitch_next_rx_data: got %h (timeout=%0d) expected %h", got, to, e);
    end
    idle(3);
    n_checks++;
    if (pwr_up !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_next_pwr_up: got %b expected 1", pwr_up);
    end
    // Return to OFF for the next scenario
    rider_off = 1'b1;
    exp_q.push_back(CMD_STOP);
    send_byte(CMD_STOP, 1'b1);
    get_obs(got, to);
    e = exp_q.pop_front();
    idle(3);
    n_checks++;
    if (to || got !== e || pwr_up !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_return_off: rx_data got %h expected %h, pwr_up got %b expected 0",
               got, e, pwr_up);
    end
    rider_off = 1'b0;
    idle(4);
  endtask

  task automatic test_frame_err();
    int ferr_before;
    ferr_before = ferr_cnt;
`ifdef SEGWAY_AUTH_FRAME_CHK_EN
    send_byte(CMD_START, 1'b0);
    idle(20);
    n_checks++;
    if (ferr_cnt - ferr_before != 1) begin
      n_fail++;
      $display("FAIL frame_err_pulses: got %0d expected 1", ferr_cnt - ferr_before);
    end
    n_checks++;
    if (obs_q.size() != 0 || pwr_up !== 1'b0 || rx_data !== CMD_STOP) begin
      n_fail++;
      $display("FAIL frame_err_suppress: frames got %0d expected 0, pwr_up %b expected 0, rx_data %h expected 53",
               obs_q.size(), pwr_up, rx_data);
    end
`else
    begin
      logic [7:0] got, e;
      bit to;
      exp_q.push_back(CMD_START);
      send_byte(CMD_START, 1'b0);
      get_obs(got, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || got !== e) begin
        n_fail++;
        $display("FAIL bad_stop_rx_data: got %h (timeout=%0d) expected %h", got, to, e);
      end
      idle(20);
      n_checks++;
      if (pwr_up !== 1'b1 || ferr_cnt != ferr_before) begin
        n_fail++;
        $display("FAIL bad_stop_ignored: pwr_up got %b expected 1, frame_err pulses got %0d expected 0",
                 pwr_up, ferr_cnt - ferr_before);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, e;
    bit to;
    logic [7:0] b;
    b = CMD_START;
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwr_up !== 1'b0 || rx_rdy !== 1'b0 || frame_err !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: pwr_up=%b rx_rdy=%b frame_err=%b rx_data=%h, expected 0 0 0 00",
               pwr_up, rx_rdy, frame_err, rx_data);
    end
    rst_n = 1'b1;
    idle(4);
    exp_q.push_back(CMD_STOP);
    send_byte(CMD_STOP, 1'b1);
    get_obs(got, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL after_reset_rx_data: got %h (timeout=%0d) expected %h", got, to, e);
    end
    idle(3);
    n_checks++;
    if (pwr_up !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_reset_pwr_up: got %b expected 0, extra frames %0d expected 0",
               pwr_up, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, e, b;
    bit to;
    rider_off = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == CMD_START) b = 8'h48;
      exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      get_obs(got, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || got !== e) begin
        n_fail++;
        $display("FAIL b2b_rx_data[%0d]: got %h (timeout=%0d) expected %h", k, got, to, e);
      end
    end
    idle(3);
    n_checks++;
    if (pwr_up !== 1'b0 || wide_cnt != 0) begin
      n_fail++;
      $display("FAIL b2b_state: pwr_up got %b expected 0, wide rx_rdy pulses got %0d expected 0",
               pwr_up, wide_cnt);
    end
    rider_off = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    RX        = 1'b1;
    rider_off = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    idle(4);
    test_start_cmd();
    test_stop_to_pwr2();
    test_regrant();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
